// File: rtl/pmem_arbiter.sv
// pmem_arbiter: serialises I-cache and D-cache line transactions onto the
// single burst pmem port. Round-robin on contention, latched address/data for
// the granted transaction, and saturating grant/wait counters.
module pmem_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,

    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,

    output logic [CNT_W-1:0]  i_grants,
    output logic [CNT_W-1:0]  d_grants,
    output logic [CNT_W-1:0]  i_wait_cycles,
    output logic [CNT_W-1:0]  d_wait_cycles,
    output logic              proto_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    // last_grant encoding: which side completed the most recent transaction
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Saturating increment: holds at all-ones instead of wrapping to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                                  input logic             en);
        logic [CNT_W-1:0] result;
        if (en && (value != CNT_MAX)) begin
            result = value + CNT_ONE;
        end else begin
            result = value;
        end
        return result;
    endfunction

    // Registered state
    state_t            state_r;
    logic              last_grant_r;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic              op_q;          // 1 = writeback, 0 = line fill
    logic              pmem_read_r;
    logic              pmem_write_r;
    logic [CNT_W-1:0]  i_grants_r;
    logic [CNT_W-1:0]  d_grants_r;
    logic [CNT_W-1:0]  i_wait_r;
    logic [CNT_W-1:0]  d_wait_r;
    logic              proto_err_r;

    // Combinational decode
    state_t            state_next_s;
    logic              i_req_s;
    logic              d_req_s;
    logic              grant_i_s;
    logic              grant_d_s;
    logic              done_i_s;
    logic              done_d_s;
    logic              op_next_s;
    logic              rd_next_s;
    logic              wr_next_s;

    assign i_req_s = i_pmem_read;
    assign d_req_s = d_pmem_read | d_pmem_write;

    // A completion only counts while the matching side is actually being served;
    // a stray pmem_resp in IDLE is dropped here.
    assign done_i_s = (state_r == SERVE_I) && pmem_resp;
    assign done_d_s = (state_r == SERVE_D) && pmem_resp;

    // Next-state and grant decision; ties go to the side not granted last.
    always_comb begin
        state_next_s = state_r;
        grant_i_s    = 1'b0;
        grant_d_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (i_req_s && d_req_s) begin
                    if (last_grant_r == GRANT_I) begin
                        grant_d_s = 1'b1;
                    end else begin
                        grant_i_s = 1'b1;
                    end
                end else if (i_req_s) begin
                    grant_i_s = 1'b1;
                end else if (d_req_s) begin
                    grant_d_s = 1'b1;
                end else begin
                    grant_i_s = 1'b0;
                    grant_d_s = 1'b0;
                end

                if (grant_i_s) begin
                    state_next_s = SERVE_I;
                end else if (grant_d_s) begin
                    state_next_s = SERVE_D;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SERVE_I: begin
                if (pmem_resp) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = SERVE_I;
                end
            end
            SERVE_D: begin
                if (pmem_resp) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = SERVE_D;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Operation type of the transaction that will be active next cycle, and the
    // pmem strobes it implies; write wins when the D side raises both.
    always_comb begin
        op_next_s = op_q;
        if (grant_d_s) begin
            op_next_s = d_pmem_write;
        end else if (grant_i_s) begin
            op_next_s = 1'b0;
        end else begin
            op_next_s = op_q;
        end
        rd_next_s = (state_next_s == SERVE_I) ||
                    ((state_next_s == SERVE_D) && !op_next_s);
        wr_next_s = (state_next_s == SERVE_D) && op_next_s;
    end

    // FSM state, round-robin pointer and registered pmem strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            last_grant_r <= GRANT_I;
            pmem_read_r  <= 1'b0;
            pmem_write_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            pmem_read_r  <= rd_next_s;
            pmem_write_r <= wr_next_s;
            if (done_i_s) begin
                last_grant_r <= GRANT_I;
            end else if (done_d_s) begin
                last_grant_r <= GRANT_D;
            end else begin
                last_grant_r <= last_grant_r;
            end
        end
    end

    // Capture address/data of the granted request so later changes on the
    // cache ports cannot disturb an in-flight burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= {ADDR_W{1'b0}};
            wdata_q <= {LINE_W{1'b0}};
            op_q    <= 1'b0;
        end else if (grant_d_s) begin
            addr_q  <= d_pmem_address;
            wdata_q <= d_pmem_wdata;
            op_q    <= d_pmem_write;
        end else if (grant_i_s) begin
            addr_q  <= i_pmem_address;
            wdata_q <= wdata_q;
            op_q    <= 1'b0;
        end else begin
            addr_q  <= addr_q;
            wdata_q <= wdata_q;
            op_q    <= op_q;
        end
    end

    // Saturating performance counters; a side waits whenever it requests and is
    // not the one being served, including the arbitration cycle in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_grants_r <= {CNT_W{1'b0}};
            d_grants_r <= {CNT_W{1'b0}};
            i_wait_r   <= {CNT_W{1'b0}};
            d_wait_r   <= {CNT_W{1'b0}};
        end else begin
            i_grants_r <= sat_inc(i_grants_r, done_i_s);
            d_grants_r <= sat_inc(d_grants_r, done_d_s);
            i_wait_r   <= sat_inc(i_wait_r, i_req_s && (state_r != SERVE_I));
            d_wait_r   <= sat_inc(d_wait_r, d_req_s && (state_r != SERVE_D));
        end
    end

    // Sticky flag for the illegal simultaneous D read+write request.
    always_ff @(posedge clk) begin
        if (rst) begin
            proto_err_r <= 1'b0;
        end else begin
            proto_err_r <= proto_err_r | (d_pmem_read & d_pmem_write);
        end
    end

    assign pmem_read     = pmem_read_r;
    assign pmem_write    = pmem_write_r;
    assign pmem_address  = addr_q;
    assign pmem_wdata    = wdata_q;

    // Completion pulses must coincide with pmem_resp, so they stay combinational.
    assign i_pmem_resp   = done_i_s;
    assign d_pmem_resp   = done_d_s;
    assign i_pmem_rdata  = pmem_rdata;
    assign d_pmem_rdata  = pmem_rdata;

    assign i_grants      = i_grants_r;
    assign d_grants      = d_grants_r;
    assign i_wait_cycles = i_wait_r;
    assign d_wait_cycles = d_wait_r;
    assign proto_err     = proto_err_r;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: a cycle table for single/tie/round-robin
// traffic, then hand sequences for address latching, stray resp, proto_err,
// counter saturation (narrow-counter instance) and mid-transaction reset.
module tb_pmem_arbiter;

    localparam logic [255:0] RDATA  = {32{8'hA5}};
    localparam logic [255:0] WDATA1 = {8{32'hDEADBEEF}};
    localparam logic [255:0] WDATA2 = {8{32'h0BADF00D}};
    localparam logic [31:0]  I_ADDR = 32'h8000_0020;
    localparam logic [31:0]  D_ADDR = 32'h0000_0100;

    logic         clk;
    logic         rst;
    logic         i_pmem_read;
    logic [31:0]  i_pmem_address;
    logic [255:0] i_pmem_rdata;
    logic         i_pmem_resp;
    logic         d_pmem_read;
    logic         d_pmem_write;
    logic [31:0]  d_pmem_address;
    logic [255:0] d_pmem_wdata;
    logic [255:0] d_pmem_rdata;
    logic         d_pmem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic [31:0]  i_grants;
    logic [31:0]  d_grants;
    logic [31:0]  i_wait_cycles;
    logic [31:0]  d_wait_cycles;
    logic         proto_err;

    // narrow-counter instance fed by the same stimulus
    logic [255:0] s_i_rdata;
    logic         s_i_resp;
    logic [255:0] s_d_rdata;
    logic         s_d_resp;
    logic         s_pmem_read;
    logic         s_pmem_write;
    logic [31:0]  s_pmem_address;
    logic [255:0] s_pmem_wdata;
    logic [1:0]   s_i_grants;
    logic [1:0]   s_d_grants;
    logic [1:0]   s_i_wait;
    logic [1:0]   s_d_wait;
    logic         s_proto_err;

    int checks;
    int passes;

    pmem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .i_grants(i_grants), .d_grants(d_grants),
        .i_wait_cycles(i_wait_cycles), .d_wait_cycles(d_wait_cycles),
        .proto_err(proto_err)
    );

    pmem_arbiter #(.CNT_W(2)) dut_small (
        .clk(clk), .rst(rst),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(s_i_rdata), .i_pmem_resp(s_i_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(s_d_rdata), .d_pmem_resp(s_d_resp),
        .pmem_read(s_pmem_read), .pmem_write(s_pmem_write),
        .pmem_address(s_pmem_address), .pmem_wdata(s_pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .i_grants(s_i_grants), .d_grants(s_d_grants),
        .i_wait_cycles(s_i_wait), .d_wait_cycles(s_d_wait),
        .proto_err(s_proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // inputs {i_rd, d_rd, d_wr, pmem_resp}; ctl {pmem_read, pmem_write, i_resp, d_resp}
    typedef struct packed {
        logic [3:0]  in;
        logic [3:0]  ctl;
        logic [31:0] addr;
        logic [31:0] ig;
        logic [31:0] dg;
        logic [31:0] iw;
        logic [31:0] dw;
    } vec_t;

    vec_t tbl [19];

    function automatic vec_t mk(input logic [3:0] in, input logic [3:0] ctl,
                                input logic [31:0] addr, input logic [31:0] ig,
                                input logic [31:0] dg, input logic [31:0] iw,
                                input logic [31:0] dw);
        vec_t v;
        v.in = in; v.ctl = ctl; v.addr = addr;
        v.ig = ig; v.dg = dg; v.iw = iw; v.dw = dw;
        return v;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // advance to just after the next rising edge; inputs are driven here
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        rst = 1'b1;
        i_pmem_read = 1'b0; i_pmem_address = I_ADDR;
        d_pmem_read = 1'b0; d_pmem_write = 1'b0;
        d_pmem_address = D_ADDR; d_pmem_wdata = WDATA1;
        pmem_rdata = RDATA; pmem_resp = 1'b0;

        tbl[0]  = mk(4'b1000, 4'b0000, 32'h0,  32'd0, 32'd0, 32'd0, 32'd0);
        tbl[1]  = mk(4'b1000, 4'b1000, I_ADDR, 32'd0, 32'd0, 32'd1, 32'd0);
        tbl[2]  = mk(4'b1000, 4'b1000, I_ADDR, 32'd0, 32'd0, 32'd1, 32'd0);
        tbl[3]  = mk(4'b1000, 4'b1000, I_ADDR, 32'd0, 32'd0, 32'd1, 32'd0);
        tbl[4]  = mk(4'b1000, 4'b1000, I_ADDR, 32'd0, 32'd0, 32'd1, 32'd0);
        tbl[5]  = mk(4'b1001, 4'b1010, I_ADDR, 32'd0, 32'd0, 32'd1, 32'd0);
        tbl[6]  = mk(4'b0000, 4'b0000, I_ADDR, 32'd1, 32'd0, 32'd1, 32'd0);
        tbl[7]  = mk(4'b1010, 4'b0000, I_ADDR, 32'd1, 32'd0, 32'd1, 32'd0);
        tbl[8]  = mk(4'b1010, 4'b0100, D_ADDR, 32'd1, 32'd0, 32'd2, 32'd1);
        tbl[9]  = mk(4'b1010, 4'b0100, D_ADDR, 32'd1, 32'd0, 32'd3, 32'd1);
        tbl[10] = mk(4'b1011, 4'b0101, D_ADDR, 32'd1, 32'd0, 32'd4, 32'd1);
        tbl[11] = mk(4'b1010, 4'b0000, D_ADDR, 32'd1, 32'd1, 32'd5, 32'd1);
        tbl[12] = mk(4'b1010, 4'b1000, I_ADDR, 32'd1, 32'd1, 32'd6, 32'd2);
        tbl[13] = mk(4'b1010, 4'b1000, I_ADDR, 32'd1, 32'd1, 32'd6, 32'd3);
        tbl[14] = mk(4'b1011, 4'b1010, I_ADDR, 32'd1, 32'd1, 32'd6, 32'd4);
        tbl[15] = mk(4'b0010, 4'b0000, I_ADDR, 32'd2, 32'd1, 32'd6, 32'd5);
        tbl[16] = mk(4'b0010, 4'b0100, D_ADDR, 32'd2, 32'd1, 32'd6, 32'd6);
        tbl[17] = mk(4'b0011, 4'b0101, D_ADDR, 32'd2, 32'd1, 32'd6, 32'd6);
        tbl[18] = mk(4'b0000, 4'b0000, D_ADDR, 32'd2, 32'd2, 32'd6, 32'd6);

        // reset state
        tick(); tick();
        check("reset ctl", {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp, proto_err}, 5'b00000);
        check("reset counters", {i_grants, d_grants, i_wait_cycles, d_wait_cycles}, 128'd0);
        check("reset addr", pmem_address, 32'h0);
        check("reset wdata", pmem_wdata, 256'd0);
        rst = 1'b0;

        // single I fill, then tie (D wins), then repeated tie (I wins)
        for (int k = 0; k < 19; k++) begin
            tick();
            i_pmem_read  = tbl[k].in[3];
            d_pmem_read  = tbl[k].in[2];
            d_pmem_write = tbl[k].in[1];
            pmem_resp    = tbl[k].in[0];
            #1;
            check($sformatf("row%0d ctl", k), {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp}, tbl[k].ctl);
            check($sformatf("row%0d addr", k), pmem_address, tbl[k].addr);
            check($sformatf("row%0d counters", k), {i_grants, d_grants, i_wait_cycles, d_wait_cycles},
                  {tbl[k].ig, tbl[k].dg, tbl[k].iw, tbl[k].dw});
            if (tbl[k].ctl[1]) begin
                check($sformatf("row%0d i_rdata", k), i_pmem_rdata, RDATA);
            end
        end
        check("latched wdata", pmem_wdata, WDATA1);
        check("narrow counters", {s_i_grants, s_d_grants, s_i_wait, s_d_wait}, 8'b10_10_11_11);

        // three more I fills: narrow grant counter saturates at 3
        i_pmem_address = 32'h8000_0040;
        for (int t = 0; t < 3; t++) begin
            tick(); i_pmem_read = 1'b1; #1;
            tick(); #1;
            check($sformatf("loop%0d serve", t), {pmem_read, pmem_address}, {1'b1, 32'h8000_0040});
            tick(); pmem_resp = 1'b1; #1;
            check($sformatf("loop%0d resp", t), i_pmem_resp, 1'b1);
            tick(); i_pmem_read = 1'b0; pmem_resp = 1'b0; #1;
            check($sformatf("loop%0d idle", t), pmem_read, 1'b0);
        end
        check("i counters after loop", {i_grants, i_wait_cycles}, {32'd5, 32'd9});
        check("narrow i saturated", {s_i_grants, s_i_wait}, 4'b11_11);

        // D read whose cache-side address changes mid-burst
        tick(); d_pmem_read = 1'b1; d_pmem_address = 32'h100; #1;
        tick(); d_pmem_address = 32'h200; #1;
        check("stable addr 1", {pmem_read, pmem_write, pmem_address}, {2'b10, 32'h100});
        tick(); #1;
        check("stable addr 2", pmem_address, 32'h100);
        tick(); pmem_resp = 1'b1; #1;
        check("d read resp", {d_pmem_resp, pmem_address}, {1'b1, 32'h100});
        check("d rdata", d_pmem_rdata, RDATA);
        tick(); d_pmem_read = 1'b0; pmem_resp = 1'b0; #1;
        check("d read done", {pmem_read, pmem_write}, 2'b00);

        // stray pmem_resp while IDLE
        tick(); pmem_resp = 1'b1; #1;
        check("idle resp ignored", {i_pmem_resp, d_pmem_resp}, 2'b00);
        tick(); pmem_resp = 1'b0; #1;
        check("idle counters", {i_grants, d_grants, i_wait_cycles, d_wait_cycles},
              {32'd5, 32'd3, 32'd9, 32'd7});
        check("idle no strobe", {pmem_read, pmem_write}, 2'b00);

        // D read and write together: write performed, sticky proto_err
        check("proto_err clear", proto_err, 1'b0);
        tick(); d_pmem_read = 1'b1; d_pmem_write = 1'b1;
        d_pmem_address = 32'h300; d_pmem_wdata = WDATA2; #1;
        check("proto_err registered", proto_err, 1'b0);
        tick(); #1;
        check("both high -> write", {pmem_read, pmem_write, proto_err, pmem_address}, {3'b011, 32'h300});
        check("both high wdata", pmem_wdata, WDATA2);
        tick(); pmem_resp = 1'b1; #1;
        check("both high resp", d_pmem_resp, 1'b1);
        tick(); d_pmem_read = 1'b0; d_pmem_write = 1'b0; pmem_resp = 1'b0; #1;
        check("proto_err sticky 1", {proto_err, pmem_read, pmem_write}, 3'b100);
        tick(); #1;
        check("proto_err sticky 2", proto_err, 1'b1);
        tick(); rst = 1'b1; #1;
        tick(); rst = 1'b0; #1;
        check("proto_err cleared", proto_err, 1'b0);
        check("counters cleared", {i_grants, d_grants, i_wait_cycles, d_wait_cycles}, 128'd0);
        check("latches cleared", {pmem_address, pmem_wdata}, 288'd0);

        // reset two cycles into an I fill
        i_pmem_address = I_ADDR;
        tick(); i_pmem_read = 1'b1; #1;
        tick(); #1;
        check("rst seq serve", pmem_read, 1'b1);
        tick(); rst = 1'b1; #1;
        check("rst seq still serving", pmem_read, 1'b1);
        tick(); rst = 1'b0; i_pmem_read = 1'b0; pmem_resp = 1'b1; #1;
        check("rst seq abandoned", {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp}, 4'b0000);
        check("rst seq counters", {i_grants, d_grants, i_wait_cycles, d_wait_cycles}, 128'd0);
        tick(); pmem_resp = 1'b0; #1;
        check("rst seq idle", {pmem_read, i_grants}, 33'd0);
        check("narrow final ctl", {s_pmem_read, s_pmem_write, s_i_resp, s_d_resp, s_proto_err,
              s_i_grants, s_d_grants, s_i_wait, s_d_wait}, 13'd0);
        check("narrow final latches", {s_pmem_address, s_pmem_wdata}, 288'd0);
        check("narrow rdata", {s_i_rdata, s_d_rdata}, {RDATA, RDATA});

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
